// File: rtl/icsp_loader.sv
// ICSP programming slave: shifts commands and data in from a two-wire serial link,
// drives the program-memory write port, serves read-back and holds the CPU in reset.
module icsp_loader #(
  parameter int ADDR_W      = 12,
  parameter int PROG_CYCLES = 8,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              icsp_clk,
  input  logic              icsp_data_in,
  output logic              icsp_data_out,
  output logic              icsp_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [13:0]       mem_wdata,
  output logic              mem_we,
  input  logic [13:0]       mem_rdata,
  output logic              busy,
  output logic              cpu_hold
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_PROG   = 3'd5;

  localparam logic [5:0] CMD_LOAD = 6'h02;
  localparam logic [5:0] CMD_READ = 6'h04;
  localparam logic [5:0] CMD_INC  = 6'h06;
  localparam logic [5:0] CMD_PROG = 6'h08;

  logic [1:0]        pm_q, dt_q;
  logic [2:0]        ck_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [13:0]       latch_q, latch_d;
  logic [15:0]       sr_q, sr_d, sr_shift;
  logic [15:0]       ofr_q, ofr_d;
  logic [4:0]        bcnt_q, bcnt_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              out_q, out_d, oe_q, oe_d, we_q, we_d, busy_q, busy_d, hold_q;
  logic              pm, din, rise, fall;

  // Edges come from the last two synchronised stages so the data stage lines up.
  assign pm       = pm_q[1];
  assign din      = dt_q[1];
  assign rise     = ck_q[1] & ~ck_q[2];
  assign fall     = ck_q[2] & ~ck_q[1];
  assign sr_shift = {din, sr_q[15:1]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    latch_d = latch_q;
    sr_d    = sr_q;
    ofr_d   = ofr_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    out_d   = out_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pm) begin
          state_d = S_CMD;
          bcnt_d  = '0;
          sr_d    = '0;
        end
      end
      S_CMD: begin
        if (fall) begin
          sr_d = sr_shift;
          if (bcnt_q == 5'd5) begin
            bcnt_d = '0;
            case (sr_shift[15:10])
              CMD_LOAD: state_d = S_LOAD;
              CMD_READ: begin
                state_d = S_RDWAIT;
                wcnt_d  = '0;
              end
              CMD_INC:  addr_d = addr_q + ADDR_W'(1);
              CMD_PROG: begin
                state_d = S_PROG;
                wcnt_d  = '0;
                we_d    = 1'b1;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end
      S_LOAD: begin
        if (fall) begin
          sr_d = sr_shift;
          if (bcnt_q == 5'd15) begin
            latch_d = sr_shift[14:1];
            bcnt_d  = '0;
            state_d = S_CMD;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end
      S_RDWAIT: begin
        if (wcnt_q == 16'(READ_LAT)) begin
          ofr_d   = {1'b0, mem_rdata, 1'b0};
          oe_d    = 1'b1;
          bcnt_d  = '0;
          state_d = S_READ;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_READ: begin
        if (rise) begin
          out_d = ofr_q[0];
          ofr_d = {1'b0, ofr_q[15:1]};
        end
        if (fall) begin
          if (bcnt_q == 5'd15) begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            bcnt_d  = '0;
            state_d = S_CMD;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end
      S_PROG: begin
        if (wcnt_q == 16'(PROG_CYCLES - 1)) begin
          busy_d  = 1'b0;
          bcnt_d  = '0;
          state_d = S_CMD;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping prog_mode overrides whatever the current state decided this cycle.
    if (state_q != S_IDLE && !pm) begin
      state_d = S_IDLE;
      addr_d  = '0;
      latch_d = 14'h3FFF;
      sr_d    = '0;
      ofr_d   = '0;
      bcnt_d  = '0;
      wcnt_d  = '0;
      out_d   = 1'b0;
      oe_d    = 1'b0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_q    <= '0;
      dt_q    <= '0;
      ck_q    <= '0;
      state_q <= S_IDLE;
      addr_q  <= '0;
      latch_q <= 14'h3FFF;
      sr_q    <= '0;
      ofr_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      pm_q    <= {pm_q[0], prog_mode};
      dt_q    <= {dt_q[0], icsp_data_in};
      ck_q    <= {ck_q[1:0], icsp_clk};
      state_q <= state_d;
      addr_q  <= addr_d;
      latch_q <= latch_d;
      sr_q    <= sr_d;
      ofr_q   <= ofr_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      hold_q  <= pm | (state_d != S_IDLE);
    end
  end

  assign icsp_data_out = out_q;
  assign icsp_data_oe  = oe_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = latch_q;
  assign mem_we        = we_q;
  assign busy          = busy_q;
  assign cpu_hold      = hold_q;

endmodule

// File: doc/icsp_loader.md
Name: icsp_loader

Overview:
- Serial in-circuit programming (ICSP) slave for the PIC16F84 core: the write side of flash program memory, which the fetch path only reads.
- Receives 6-bit commands and 14-bit data words over a two-wire serial link (icsp_clk, icsp_data_in).
- Drives the program-memory write port, and serves read-back through icsp_data_out.
- Holds the CPU in reset while programming mode is active.

Parameters:
- ADDR_W, 12: program-memory address width, same as the PC width.
- PROG_CYCLES, 8: clk cycles the block stays busy after Begin Programming; minimum 1.
- READ_LAT, 1: clk cycles from mem_addr to valid mem_rdata (synchronous memory read).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prog_mode  in  1  programming-mode request (MCLR/VPP equivalent); asynchronous, level
- icsp_clk  in  1  serial clock from the programmer; asynchronous to clk
- icsp_data_in  in  1  serial data from the programmer
- icsp_data_out  out  1  serial read-back data
- icsp_data_oe  out  1  high while the block drives the data line
- mem_addr  out  ADDR_W  program-memory address
- mem_wdata  out  14  program-memory write data
- mem_we  out  1  one-cycle write strobe
- mem_rdata  in  14  program-memory read data
- busy  out  1  programming cycle in progress
- cpu_hold  out  1  CPU reset request; OR into the pc reset

Behaviour:

Input synchronisation
- prog_mode, icsp_clk and icsp_data_in each pass through a 2-flop synchroniser.
- Rise and fall of icsp_clk are detected from the synchronised copy.
- The programmer guarantees icsp_clk high and low phases of at least 4 clk cycles each.

Bit timing
- Input bits are sampled on synchronised icsp_clk falling edges, LSB first.
- Output bits change on synchronised rising edges.

Reset values
- State IDLE; mem_addr=0; data latch=0x3FFF (erased value); shift registers and bit counter =0.
- mem_we=0, busy=0, icsp_data_out=0, icsp_data_oe=0.
- cpu_hold=0.

cpu_hold
- cpu_hold = synced prog_mode OR (state != IDLE). Registered, so it follows prog_mode 3 clk cycles after the input changes.

State machine
- IDLE: icsp edges are ignored. On synced prog_mode=1, go to CMD with bit counter=0.
- CMD: shift in 6 bits. After the 6th falling edge, decode cmd[5:0]:
  - 0x02 Load Data: go to LOAD.
  - 0x04 Read Data: go to RDWAIT.
  - 0x06 Increment Address: mem_addr <= mem_addr+1, modulo 2^ADDR_W (wraps to 0 after the maximum address); stay in CMD.
  - 0x08 Begin Programming: go to PROG.
  - Any other value: ignored; stay in CMD.
- LOAD: shift in a 16-bit frame. After the 16th falling edge, latch = frame[14:1]; frame bits 0 and 15 (start/stop) are ignored. Return to CMD.
- RDWAIT: wait READ_LAT+1 clk cycles, capture mem_rdata into the output frame {0, data[13:0], 0}, then go to READ.
- READ:
  - icsp_data_oe=1 from entry until the 16th falling edge.
  - Each rising edge presents the next frame bit, start bit first.
  - After the 16th falling edge: icsp_data_oe=0, icsp_data_out=0, return to CMD.
- PROG:
  - First cycle: mem_we=1 for exactly one clk, with mem_wdata=latch and mem_addr stable.
  - busy=1 for PROG_CYCLES cycles starting that same cycle; icsp edges are ignored throughout.
  - Then go to CMD. The latch is not cleared, so repeated Begin Programming commands rewrite the same word.

Fixed relationships
- mem_wdata always reflects the latch.
- mem_addr changes only on Increment Address, abort, or reset.

Abort
- Synced prog_mode=0 in any state, or reset, forces IDLE on the next clk: mem_addr=0, latch=0x3FFF, counters=0, oe=0, busy=0.
- A mem_we already issued is not retracted; no further mem_we pulse follows.

Simultaneous events
- reset dominates the prog_mode drop, which dominates icsp edges.
- An icsp edge coincident with prog_mode rising is ignored, because the block is still in IDLE.

Test Plan:
- Write/readback: prog_mode=1; Load Data frame data=0x2A5C; Begin Programming → one mem_we pulse with addr=0, wdata=0x2A5C, busy high 8 cycles. Read Data with mem_rdata=0x2A5C → icsp_data_out sequence 0, then bits of 0x2A5C LSB first, then 0; icsp_data_oe high across all 16 bits.
- Address walk/wrap: Increment Address issued 4096 times (ADDR_W=12) → mem_addr steps 1,2,…,4095 and then reads 0; no mem_we throughout.
- Unknown command 0x3F, then Load Data 0x0001 and Begin Programming → nothing happens on 0x3F; the write lands at addr 0 with data 0x0001.
- Abort mid-LOAD: after 9 of 16 data bits, drop prog_mode → IDLE, latch=0x3FFF, mem_addr=0, cpu_hold falls about 3 clk later. Re-entering and sending Begin Programming writes 0x3FFF.
- Busy lockout: during PROG, toggle icsp_clk with a Load Data command pattern → ignored. After busy falls, a fresh command decodes correctly.
- Reset with prog_mode=1 during READ → next cycle icsp_data_oe=0, state IDLE, then CMD on the following cycles; a clean 6-bit command then decodes correctly.
